// File: rtl/rpe_weight_loader_pkg.sv
// Shared definitions for the RPE weight-load path: code widths, code constants
// and the loader state encoding.
package rpe_weight_loader_pkg;

  localparam int RPE_W_CODE_W = 5;
  localparam int RPE_ACT_W    = 7;

  localparam logic [RPE_W_CODE_W-1:0] CODE_ZERO = 5'b10000;
  localparam logic                    F_MSR4    = 1'b0;
  localparam logic                    F_MULT16  = 1'b1;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_SHIFT = 1'b1
  } ld_state_t;

endpackage

// File: rtl/rpe_weight_quant.sv
// Combinational int8 -> 5-bit RPE weight code quantiser with an inexact flag.
module rpe_weight_quant
  import rpe_weight_loader_pkg::*;
(
  input  logic signed [7:0]              w,
  output logic        [RPE_W_CODE_W-1:0] code,
  output logic                           inexact
);

  function automatic logic [3:0] odd_c(input logic signed [7:0] v);
    return 4'((v - 8'sd1) >>> 1);
  endfunction

  // Nearest multiple of 16 with ties away from zero, clamped to 7*16.
  function automatic logic [3:0] round_sat_m(input logic [7:0] mag);
    logic [4:0] q;
    q = 5'((9'(mag) + 9'd8) >> 4);
    return (q > 5'd7) ? 4'd7 : q[3:0];
  endfunction

  logic [7:0] mag;
  logic [3:0] m;

  always_comb begin
    code    = CODE_ZERO;
    inexact = 1'b0;
    mag     = w[7] ? 8'(-w) : 8'(w);
    m       = round_sat_m(mag);
    if (w == 8'sd0) begin
      code = CODE_ZERO;
    end else if (mag <= 8'd15) begin
      if (w[0]) begin
        code = {F_MSR4, odd_c(w)};
      end else begin
        inexact = 1'b1;
        code    = {F_MSR4, odd_c(w[7] ? w + 8'sd1 : w - 8'sd1)};
      end
    end else begin
      inexact = ({m, 4'b0000} != mag);
      // m is 1..7 here, so the inverted form never reaches 4'b1111
      code    = w[7] ? {F_MULT16, ~m} : {F_MULT16, m};
    end
  end

endmodule

// File: rtl/rpe_weight_loader.sv
// Loads one column of int8 weights, quantises them, and shifts the codes
// into a systolic-array column bottom row first.
module rpe_weight_loader
  import rpe_weight_loader_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int IDX_W = $clog2(SIZE),
  parameter int ERR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    w_in_valid,
  output logic                    w_in_ready,
  input  logic signed [7:0]       w_in,
  input  logic                    err_clr,
  output logic [RPE_W_CODE_W-1:0] Weight_out,
  output logic                    Weight_out_valid,
  output logic                    load_done,
  output logic [ERR_W-1:0]        quant_err_cnt
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE - 1);

  ld_state_t               state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [RPE_W_CODE_W-1:0] code_p0;
  logic                    inexact_p0;
  logic                    accept;
  logic [RPE_W_CODE_W-1:0] beat_code;
  logic [RPE_W_CODE_W-1:0] wbuf [SIZE];

  rpe_weight_quant u_quant (
    .w       (w_in),
    .code    (code_p0),
    .inexact (inexact_p0)
  );

  assign w_in_ready = rst_n && (state == ST_FILL);
  assign accept     = w_in_valid && w_in_ready;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_FILL: begin
        if (accept) begin
          if (idx == IDX_LAST) begin
            state_nxt = ST_SHIFT;
            idx_nxt   = IDX_LAST;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (idx == '0) begin
          state_nxt = ST_FILL;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx - 1'b1;
        end
      end
      default: begin
        state_nxt = ST_FILL;
        idx_nxt   = '0;
      end
    endcase
    // The first beat bypasses the buffer: its row is being written this cycle.
    beat_code = (state == ST_FILL) ? code_p0 : wbuf[idx_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FILL;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) wbuf[idx] <= code_p0;
  end

  // ---- output stage: beat registered on the edge entering each SHIFT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Weight_out       <= '0;
      Weight_out_valid <= 1'b0;
      load_done        <= 1'b0;
    end else begin
      Weight_out_valid <= (state_nxt == ST_SHIFT);
      load_done        <= (state == ST_SHIFT) && (idx == '0);
      if (state_nxt == ST_SHIFT) Weight_out <= beat_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quant_err_cnt <= '0;
    end else if (err_clr) begin
      quant_err_cnt <= '0;
    end else if (accept && inexact_p0 && (quant_err_cnt != '1)) begin
      quant_err_cnt <= quant_err_cnt + 1'b1;
    end
  end

endmodule
